// File: rtl/ahb_wr_stream_feeder.sv
// Stream-to-UI write feeder for ahb_master: FIFO-buffers a valid/ready stream and issues one write burst per command.
// Optional AHB_FEEDER_XPROP_EN: o_ui_data driven to x whenever o_ui_dav=0.
module ahb_wr_stream_feeder #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic [DATA_WDT-1:0] i_s_data,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [2:0]          i_cmd_size,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ui_wr,
  output logic                o_ui_cont,
  output logic                o_ui_dav,
  output logic [DATA_WDT-1:0] o_ui_data,
  output logic [31:0]         o_ui_addr,
  output logic [2:0]          o_ui_size,
  output logic [BEAT_WDT-1:0] o_ui_min_len,
  input  logic                i_ui_next
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FIRST, ACTIVE} state_e;

  logic [DATA_WDT-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]       cnt_q, avail;
  logic                push, pop;

  state_e              state_q, state_d;
  logic [31:0]         caddr_q, caddr_d, uaddr_q, uaddr_d;
  logic [2:0]          csize_q, csize_d, usize_q, usize_d;
  logic [BEAT_WDT-1:0] clen_q, clen_d, ulen_q, ulen_d, beats_q, beats_d;
  logic                wr_q, wr_d, cont_q, cont_d, dav_q, dav_d, done_q, done_d;
  logic [DATA_WDT-1:0] data_q, data_d;

  assign o_s_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign push      = i_s_valid & o_s_ready;
  assign rd_nxt    = rd_ptr_q + 1'b1;
  assign avail     = cnt_q - CW'(pop);

  always_ff @(posedge i_hclk) begin
    if (push) mem_q[wr_ptr_q] <= i_s_data;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_nxt;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    caddr_d = caddr_q;
    csize_d = csize_q;
    clen_d  = clen_q;
    uaddr_d = uaddr_q;
    usize_d = usize_q;
    ulen_d  = ulen_q;
    beats_d = beats_q;
    wr_d    = wr_q;
    cont_d  = cont_q;
    dav_d   = dav_q;
    data_d  = data_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          caddr_d = i_cmd_addr;
          csize_d = i_cmd_size;
          clen_d  = i_cmd_len;
          beats_d = i_cmd_len;
          if (i_cmd_len == '0) done_d  = 1'b1;
          else                 state_d = FIRST;
        end
      end
      FIRST: begin
        if (cnt_q != '0) begin
          wr_d    = 1'b1;
          cont_d  = 1'b0;
          dav_d   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          uaddr_d = caddr_q;
          usize_d = csize_q;
          ulen_d  = clen_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (i_ui_next) begin
          pop = dav_q;
          if (dav_q && beats_q != '0) beats_d = beats_q - 1'b1;
          if (dav_q && beats_q <= BEAT_WDT'(1)) begin
            wr_d    = 1'b0;
            cont_d  = 1'b0;
            dav_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cont_d = 1'b1;
            // the current head is still in mem_q this cycle, so a pop means the next beat sits one slot on
            if (avail != '0) begin
              dav_d  = 1'b1;
              data_d = pop ? mem_q[rd_nxt] : mem_q[rd_ptr_q];
            end else begin
              dav_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= IDLE;
      caddr_q <= '0;
      csize_q <= '0;
      clen_q  <= '0;
      uaddr_q <= '0;
      usize_q <= '0;
      ulen_q  <= '0;
      beats_q <= '0;
      wr_q    <= 1'b0;
      cont_q  <= 1'b0;
      dav_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      csize_q <= csize_d;
      clen_q  <= clen_d;
      uaddr_q <= uaddr_d;
      usize_q <= usize_d;
      ulen_q  <= ulen_d;
      beats_q <= beats_d;
      wr_q    <= wr_d;
      cont_q  <= cont_d;
      dav_q   <= dav_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_ui_wr      = wr_q;
  assign o_ui_cont    = cont_q;
  assign o_ui_dav     = dav_q;
  assign o_ui_addr    = uaddr_q;
  assign o_ui_size    = usize_q;
  assign o_ui_min_len = ulen_q;
`ifdef AHB_FEEDER_XPROP_EN
  assign o_ui_data    = dav_q ? data_q : {DATA_WDT{1'bx}};
`else
  assign o_ui_data    = data_q;
`endif
endmodule
